router_eject_buf: RTL and testbench
===================================

ROUTER_EJECT_BUF -- requirements
Module: router_eject_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning flits of storage per VC (power of two, >=2).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port IDATA, input, 35 bits: flit from router output port; [34:33] type (01 head, 00 body, 10 tail, 11 head+tail), [32:0] payload.
REQ-005 SHALL have port IVALID, input, 1 bit: IDATA valid this cycle.
REQ-006 SHALL have port IVCH, input, 1 bit: VC of incoming flit.
REQ-007 SHALL have port OACK, output, 2 bits: per-VC one-cycle accept pulse back to router.
REQ-008 SHALL have port ORDY, output, 2 bits: per-VC buffer has a free slot.
REQ-009 SHALL have port OLCK, output, 2 bits: per-VC packet in progress.
REQ-010 SHALL have port ODATA, output, 35 bits: flit to local core.
REQ-011 SHALL have port OVALID, output, 1 bit: ODATA valid.
REQ-012 SHALL have port OVCH, output, 1 bit: VC of ODATA.
REQ-013 SHALL have port IREADY, input, 1 bit: core accepts flit.
REQ-014 SHALL have port OERR, output, 1 bit: sticky protocol/overflow error.

Function
REQ-015 SHALL keep one DEPTH-entry FIFO per VC with count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-016 ORDY[v] SHALL equal (count[v] < DEPTH) from registered count, independent of same-cycle pop.
REQ-017 Flit SHALL be accepted at edge where IVALID && ORDY[IVCH]; OACK[IVCH] SHALL be 1 for exactly the following cycle, other OACK bit 0.
REQ-018 IVALID to VC with ORDY[IVCH]=0 SHALL drop flit, give no OACK, set OERR.
REQ-019 OLCK[v] SHALL set on accepted head (01), clear on accepted tail (10); head+tail (11) and body leave it unchanged.
REQ-020 Accepted head while OLCK[v]=1, or body/tail while OLCK[v]=0, SHALL set OERR; flit still stored.
REQ-021 OVALID SHALL be 1 when a granted VC FIFO is non-empty; ODATA/OVCH SHALL be that FIFO's head; write-to-OVALID latency 1 cycle, no bypass.
REQ-022 Pop SHALL occur at edge where OVALID && IREADY.
REQ-023 Grant SHALL be round-robin per flit: if both VCs non-empty, grant VC other than last popped; if one non-empty, grant it.
REQ-024 While OVALID && !IREADY, grant, ODATA and OVCH SHALL remain stable.
REQ-025 Simultaneous push and pop on same VC SHALL both take effect; count unchanged.
REQ-026 OERR SHALL stay 1 until reset.

Reset
REQ-027 RST_=0 SHALL asynchronously clear counts, pointers, OLCK, OACK, OERR, OVALID, last-grant (=VC1, so VC0 wins first); ORDY SHALL read 2'b11 during and after reset.
REQ-028 Reset mid-packet SHALL discard all stored flits; ODATA value is don't-care while OVALID=0.

Configuration
REQ-029 With EJECT_PKT_CNT_EN defined, SHALL add output PKT_CNT, 16 bits, reset 0, incrementing on each pop of a tail or head+tail flit, wrapping 16'hFFFF->0.
REQ-030 Without EJECT_PKT_CNT_EN, PKT_CNT port and logic SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset, then head+tail 35'h6_0000_0001 on VC0, IREADY=1 -> OACK=01 next cycle, OVALID with same data one cycle after accept, OLCK stays 00, OERR=0.
REQ-032 IREADY=0, four flits (head, body, body, tail) to VC1 with DEPTH=4 -> ORDY=01 after fourth, OLCK[1]=1 after head, cleared after tail; fifth flit dropped, no OACK, OERR=1.
REQ-033 Both VCs hold 2 flits, IREADY=1 -> OVCH sequence 0,1,0,1.
REQ-034 OVALID held with IREADY=0 while other VC fills -> ODATA/OVCH unchanged until IREADY=1.
REQ-035 Body flit on idle VC0 -> stored, OACK[0] pulse, OERR=1; then RST_ low mid-cycle -> OVALID, OLCK, OERR to 0 immediately.
REQ-036 EJECT_PKT_CNT_EN defined, 3 single-flit packets popped -> PKT_CNT=3.

Source files
------------

// File: rtl/router_eject_buf.sv
// router_eject_buf
// Ejection buffer between a two-VC router output port and the local core.
// Each VC has its own DEPTH-entry FIFO. Incoming flits are acknowledged one
// cycle after acceptance. A round-robin arbiter picks which VC is presented to
// the core, and that choice is held while the core stalls.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   RST_     : asynchronous active-low reset
//   IDATA    : flit from router, [34:33] type (01 head, 00 body, 10 tail,
//              11 head+tail), [32:0] payload
//   IVALID   : IDATA valid this cycle
//   IVCH     : VC of the incoming flit
//   OACK     : per-VC one-cycle accept pulse back to the router
//   ORDY     : per-VC buffer has a free slot
//   OLCK     : per-VC packet in progress
//   ODATA    : flit presented to the core
//   OVALID   : ODATA valid
//   OVCH     : VC of ODATA
//   IREADY   : core accepts the presented flit
//   OERR     : sticky protocol / overflow error
//   PKT_CNT  : (only with EJECT_PKT_CNT_EN) count of packets delivered to the
//              core, 16 bits, wrapping
//
// Optional feature macro: EJECT_PKT_CNT_EN adds the PKT_CNT output and its counter.

module router_eject_buf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        RST_,
  input  logic [34:0] IDATA,
  input  logic        IVALID,
  input  logic        IVCH,
  output logic [1:0]  OACK,
  output logic [1:0]  ORDY,
  output logic [1:0]  OLCK,
  output logic [34:0] ODATA,
  output logic        OVALID,
  output logic        OVCH,
  input  logic        IREADY,
`ifdef EJECT_PKT_CNT_EN
  output logic [15:0] PKT_CNT,
`endif
  output logic        OERR
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] TYPE_BODY = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  logic [34:0]            mem [2][DEPTH];
  logic [1:0][PTR_W-1:0]  wr_ptr;
  logic [1:0][PTR_W-1:0]  rd_ptr;
  logic [1:0][CNT_W-1:0]  count;

  logic [1:0] flit_type;
  logic       accept;
  logic       drop;
  logic       proto_err;
  logic [1:0] push;
  logic [1:0] pop_vc;
  logic       pop;
  logic [1:0] not_empty;
  logic       rr_vc;
  logic       grant;
  logic       last_vc;
  logic       hold;
  logic       held_vc;

  // Ready is taken from the registered count only, so a pop in the same
  // cycle never opens a slot early. Counts reset to zero, which makes ORDY
  // read all-ones while reset is held.
  always_comb begin
    for (int v = 0; v < 2; v++) begin
      ORDY[v]      = count[v] < CNT_W'(DEPTH);
      not_empty[v] = count[v] != '0;
    end
  end

  // Input-side decode. A flit to a full VC is dropped and flagged. Protocol
  // checks look at the lock state of the target VC before this flit.
  always_comb begin
    flit_type = IDATA[34:33];
    accept    = IVALID && ORDY[IVCH];
    drop      = IVALID && !ORDY[IVCH];
    push[0]   = accept && !IVCH;
    push[1]   = accept && IVCH;
    proto_err = accept &&
                (((flit_type == TYPE_HEAD) && OLCK[IVCH]) ||
                 (((flit_type == TYPE_BODY) || (flit_type == TYPE_TAIL)) && !OLCK[IVCH]));
  end

  // Output arbitration. When both VCs hold data, the one not popped last wins.
  // Once a flit has been presented and stalled, the held choice overrides
  // the round-robin pick so the data the core sees cannot change under it.
  always_comb begin
    rr_vc     = (not_empty[0] && not_empty[1]) ? ~last_vc : not_empty[1];
    grant     = hold ? held_vc : rr_vc;
    OVALID    = not_empty[grant];
    OVCH      = grant;
    ODATA     = mem[grant][rd_ptr[grant]];
    pop       = OVALID && IREADY;
    pop_vc[0] = pop && !grant;
    pop_vc[1] = pop && grant;
  end

  // Storage array has no reset; stale entries are invisible once counts clear.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[IVCH][wr_ptr[IVCH]] <= IDATA;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. A push and pop
  // on the same VC in one cycle leave the count unchanged.
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (pop_vc[v]) rd_ptr[v] <= rd_ptr[v] + 1'b1;
        if (push[v] && !pop_vc[v]) begin
          count[v] <= count[v] + 1'b1;
        end else if (!push[v] && pop_vc[v]) begin
          count[v] <= count[v] - 1'b1;
        end
      end
    end
  end

  // Acknowledge, packet lock and sticky error. Head+tail flits are
  // self-contained and leave the lock untouched.
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      OACK <= 2'b00;
      OLCK <= 2'b00;
      OERR <= 1'b0;
    end else begin
      OACK <= push;
      if (accept) begin
        if (flit_type == TYPE_HEAD) begin
          OLCK[IVCH] <= 1'b1;
        end else if (flit_type == TYPE_TAIL) begin
          OLCK[IVCH] <= 1'b0;
        end
      end
      if (drop || proto_err) begin
        OERR <= 1'b1;
      end
    end
  end

  // Arbiter history. last_vc resets to VC1 so VC0 is favoured first.
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      last_vc <= 1'b1;
      hold    <= 1'b0;
      held_vc <= 1'b0;
    end else begin
      if (pop) last_vc <= grant;
      hold    <= OVALID && !IREADY;
      held_vc <= grant;
    end
  end

`ifdef EJECT_PKT_CNT_EN
  // Bit 34 is set for both tail and head+tail, i.e. the last flit of a packet.
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      PKT_CNT <= 16'h0000;
    end else if (pop && ODATA[34]) begin
      PKT_CNT <= PKT_CNT + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_router_eject_buf.sv
// tb_router_eject_buf
// Self-checking bench for router_eject_buf. A queue-based reference model
// tracks stored flits per VC, packet locks, the error flag, acknowledges and
// the presented VC. Directed scenarios run first, followed by randomized traffic
// with periodic mid-cycle resets. If EJECT_PKT_CNT_EN is defined, the bench also
// checks the packet counter.

module tb_router_eject_buf;

  localparam int DEPTH = 4;

  logic        clk;
  logic        RST_;
  logic [34:0] IDATA;
  logic        IVALID;
  logic        IVCH;
  logic [1:0]  OACK;
  logic [1:0]  ORDY;
  logic [1:0]  OLCK;
  logic [34:0] ODATA;
  logic        OVALID;
  logic        OVCH;
  logic        IREADY;
  logic        OERR;
`ifdef EJECT_PKT_CNT_EN
  logic [15:0] PKT_CNT;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [34:0] mq0[$];
  logic [34:0] mq1[$];
  logic [1:0]  m_lck;
  logic        m_err;
  logic [1:0]  m_ack;
  logic        m_last;
  logic        m_hold;
  logic        m_held;
  logic [15:0] m_pkt;

  router_eject_buf #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .RST_   (RST_),
    .IDATA  (IDATA),
    .IVALID (IVALID),
    .IVCH   (IVCH),
    .OACK   (OACK),
    .ORDY   (ORDY),
    .OLCK   (OLCK),
    .ODATA  (ODATA),
    .OVALID (OVALID),
    .OVCH   (OVCH),
    .IREADY (IREADY),
`ifdef EJECT_PKT_CNT_EN
    .PKT_CNT(PKT_CNT),
`endif
    .OERR   (OERR)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports tag/observed/expected on a miss.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Puts the model back into the state that follows reset.
  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_lck  = 2'b00;
    m_err  = 1'b0;
    m_ack  = 2'b00;
    m_last = 1'b1;
    m_hold = 1'b0;
    m_held = 1'b0;
    m_pkt  = 16'h0000;
  endtask

  // Determines which VC should be presented: a stalled flit stays put.
  // Otherwise the VC not popped last wins if both have data, or the only
  // non-empty VC wins.
  task automatic present(output logic vc, output logic vld);
    if (m_hold) vc = m_held;
    else if (mq0.size() > 0 && mq1.size() > 0) vc = ~m_last;
    else vc = (mq1.size() > 0);
    vld = vc ? (mq1.size() > 0) : (mq0.size() > 0);
  endtask

  // Advances the model across one rising edge with the given inputs.
  task automatic model_step(input logic iv, input logic ivc, input logic [34:0] id,
                            input logic ir);
    logic pv, pvld, acc;
    logic [34:0] f;
    present(pv, pvld);
    acc = iv && ((ivc ? mq1.size() : mq0.size()) < DEPTH);
    if (iv && !acc) m_err = 1'b1;
    m_hold = pvld && !ir;
    m_held = pv;
    if (pvld && ir) begin
      f = pv ? mq1.pop_front() : mq0.pop_front();
      m_last = pv;
      if (f[34]) m_pkt = m_pkt + 16'h0001;
    end
    m_ack = 2'b00;
    if (acc) begin
      if (ivc) mq1.push_back(id); else mq0.push_back(id);
      m_ack[ivc] = 1'b1;
      case (id[34:33])
        2'b01: begin if (m_lck[ivc]) m_err = 1'b1; m_lck[ivc] = 1'b1; end
        2'b10: begin if (!m_lck[ivc]) m_err = 1'b1; m_lck[ivc] = 1'b0; end
        2'b00: begin if (!m_lck[ivc]) m_err = 1'b1; end
        default: ;
      endcase
    end
  endtask

  // Compares every visible output against the model.
  task automatic checkOutput();
    logic pv, pvld;
    present(pv, pvld);
    chk("ORDY", 64'(ORDY), 64'({mq1.size() < DEPTH, mq0.size() < DEPTH}));
    chk("OACK", 64'(OACK), 64'(m_ack));
    chk("OLCK", 64'(OLCK), 64'(m_lck));
    chk("OERR", 64'(OERR), 64'(m_err));
    chk("OVALID", 64'(OVALID), 64'(pvld));
    if (pvld) begin
      chk("OVCH", 64'(OVCH), 64'(pv));
      chk("ODATA", 64'(ODATA), 64'(pv ? mq1[0] : mq0[0]));
    end
`ifdef EJECT_PKT_CNT_EN
    chk("PKT_CNT", 64'(PKT_CNT), 64'(m_pkt));
`endif
  endtask

  // Drives one cycle of inputs at a falling edge, lets the rising edge happen,
  // and checks outputs at the next falling edge.
  task automatic applyStimulus(input logic iv, input logic ivc, input logic [34:0] id,
                               input logic ir);
    IVALID = iv;
    IVCH   = ivc;
    IDATA  = id;
    IREADY = ir;
    model_step(iv, ivc, id, ir);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  // Asserts reset partway through a cycle and checks that outputs clear
  // immediately, without waiting for a clock edge.
  task automatic mid_reset();
    IVALID = 1'b0;
    #2;
    RST_ = 1'b0;
    #1;
    chk("RST_OVALID", 64'(OVALID), 64'd0);
    chk("RST_OLCK", 64'(OLCK), 64'd0);
    chk("RST_OERR", 64'(OERR), 64'd0);
    chk("RST_ORDY", 64'(ORDY), 64'd3);
    chk("RST_OACK", 64'(OACK), 64'd0);
    model_reset();
    @(negedge clk);
    RST_ = 1'b1;
    checkOutput();
  endtask

  logic [34:0] rnd_flit;
  logic        save_vc;
  logic [34:0] save_data;

  initial begin
    RST_   = 1'b0;
    IDATA  = '0;
    IVALID = 1'b0;
    IVCH   = 1'b0;
    IREADY = 1'b0;
    model_reset();
    #1;
    chk("RESET_ORDY", 64'(ORDY), 64'd3);
    chk("RESET_OVALID", 64'(OVALID), 64'd0);
    @(negedge clk);
    RST_ = 1'b1;
    checkOutput();

    // Single head+tail flit on VC0, core always ready.
    applyStimulus(1'b1, 1'b0, 35'h6_0000_0001, 1'b1);
    chk("HT_OACK", 64'(OACK), 64'd1);
    chk("HT_ODATA", 64'(ODATA), 64'h6_0000_0001);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    chk("HT_OERR", 64'(OERR), 64'd0);

    // Fill VC1 with a whole packet while the core stalls, then overflow it.
    applyStimulus(1'b1, 1'b1, 35'h2_0000_00A1, 1'b0);
    chk("FILL_OLCK_HEAD", 64'(OLCK), 64'd2);
    applyStimulus(1'b1, 1'b1, 35'h0_0000_00A2, 1'b0);
    applyStimulus(1'b1, 1'b1, 35'h1_0000_00A3, 1'b0);
    applyStimulus(1'b1, 1'b1, 35'h4_0000_00A4, 1'b0);
    chk("FILL_ORDY", 64'(ORDY), 64'd1);
    chk("FILL_OLCK_TAIL", 64'(OLCK), 64'd0);
    applyStimulus(1'b1, 1'b1, 35'h6_0000_00A5, 1'b0);
    chk("DROP_OACK", 64'(OACK), 64'd0);
    chk("DROP_OERR", 64'(OERR), 64'd1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

    // Two flits on each VC, then drain: expect alternating VCs.
    mid_reset();
    applyStimulus(1'b1, 1'b0, 35'h6_0000_0B00, 1'b0);
    applyStimulus(1'b1, 1'b1, 35'h6_0000_0B10, 1'b0);
    applyStimulus(1'b1, 1'b0, 35'h6_0000_0B01, 1'b0);
    applyStimulus(1'b1, 1'b1, 35'h6_0000_0B11, 1'b0);
    IREADY = 1'b1;
    chk("RR_VC_0", 64'(OVCH), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    chk("RR_VC_1", 64'(OVCH), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    chk("RR_VC_2", 64'(OVCH), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    chk("RR_VC_3", 64'(OVCH), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);

    // A stalled VC1 flit must stay put while VC0 fills behind it.
    applyStimulus(1'b1, 1'b1, 35'h6_0000_0C10, 1'b0);
    save_vc   = OVCH;
    save_data = ODATA;
    applyStimulus(1'b1, 1'b0, 35'h6_0000_0C00, 1'b0);
    applyStimulus(1'b1, 1'b0, 35'h6_0000_0C01, 1'b0);
    chk("STALL_OVCH", 64'(OVCH), 64'(save_vc));
    chk("STALL_ODATA", 64'(ODATA), 64'(save_data));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

    // Body flit on an idle VC flags an error but is still stored.
    applyStimulus(1'b1, 1'b0, 35'h0_0000_0D00, 1'b0);
    chk("BODY_OACK", 64'(OACK), 64'd1);
    chk("BODY_OERR", 64'(OERR), 64'd1);
    mid_reset();

`ifdef EJECT_PKT_CNT_EN
    // Three single-flit packets delivered to the core.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 35'h6_0000_0E00 + 35'(i), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    chk("PKT_CNT_3", 64'(PKT_CNT), 64'd3);
    mid_reset();
`endif

    // Random traffic with random core back-pressure and periodic resets.
    for (int i = 0; i < 600; i++) begin
      rnd_flit = {2'($urandom), 1'($urandom), 32'($urandom)};
      applyStimulus(1'($urandom_range(1, 0)), 1'($urandom), rnd_flit,
                    ($urandom_range(9, 0) < 6));
      if (i % 150 == 149) mid_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
